// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues register-file commands to an external combinational ALU and returns results over valid/ready
module alu_issue_ctrl #(
  parameter int NREG = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_rs1,
  input  logic [1:0] cmd_rs2,
  input  logic [3:0] cmd_imm,
  output logic [2:0] S,
  output logic [3:0] A,
  output logic [3:0] B,
  input  logic [4:0] result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [4:0] rsp_data,
  output logic [1:0] rsp_rd,
  output logic       flag
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t     r_state, w_next;
  logic [3:0] r_rf [NREG];
  logic [1:0] r_rd;
  logic       w_accept;
  assign w_accept  = (r_state == IDLE) && cmd_valid;
  assign cmd_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  always_comb begin
    w_next = IDLE;
    w_next = (r_state == IDLE) ? (cmd_valid ? (cmd_load ? RESP : EXEC) : IDLE) :
             (r_state == EXEC) ? RESP :
             (r_state == RESP) ? (rsp_ready ? IDLE : RESP) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // Reset drops any in-flight op before writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S        <= '0;
      A        <= '0;
      B        <= '0;
      r_rd     <= '0;
      rsp_data <= '0;
      rsp_rd   <= '0;
      flag     <= 1'b0;
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (w_accept && !cmd_load) begin
      S    <= cmd_op;
      A    <= r_rf[cmd_rs1];
      B    <= r_rf[cmd_rs2];
      r_rd <= cmd_rd;
    end else if (w_accept) begin
      r_rf[cmd_rd] <= cmd_imm;
      rsp_data     <= {1'b0, cmd_imm};
      rsp_rd       <= cmd_rd;
    end else if (r_state == EXEC) begin
      r_rf[r_rd] <= result[3:0];
      flag       <= result[4];
      rsp_data   <= result;
      rsp_rd     <= r_rd;
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: random and directed checks of alu_issue_ctrl against a register-file/ALU reference model
module tb_alu_issue_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_load;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [3:0] cmd_imm;
  logic [2:0] S;
  logic [3:0] A, B;
  logic [4:0] result;
  logic       rsp_valid, rsp_ready;
  logic [4:0] rsp_data;
  logic [1:0] rsp_rd;
  logic       flag;

  int errs = 0;
  int checks = 0;

  logic [3:0] m_reg [4];
  logic       m_flag;
  logic [2:0] m_s;
  logic [3:0] m_a, m_b;

  always #5 clk = ~clk;

  // External ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 eq, 7 not
  function automatic logic [4:0] alu_ref(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    int x, y;
    x = int'(a);
    y = int'(b);
    case (s)
      3'd0:    return 5'((x + y) % 32);
      3'd1:    return 5'((x - y + 32) % 32);
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return 5'((x * 2) % 32);
      3'd6:    return (x == y) ? 5'd1 : 5'd0;
      default: return 5'(15 - x);
    endcase
  endfunction

  assign result = alu_ref(S, A, B);

  alu_issue_ctrl #(.NREG(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1),
    .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm), .S(S), .A(A), .B(B), .result(result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .flag(flag)
  );

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 4'd0;
    m_flag = 1'b0;
    m_s = 3'd0;
    m_a = 4'd0;
    m_b = 4'd0;
  endtask

  // Issues one command at a negedge, checks EXEC/RESP against the model, stalls RESP for 'stall' cycles.
  task automatic issue(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [1:0] rs2, input logic [3:0] imm, input int stall);
    logic [4:0] exp_d;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL issue_ready: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_rd = rd;
    cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_load = 1'($urandom); cmd_op = 3'($urandom); cmd_rd = 2'($urandom);
    cmd_rs1 = 2'($urandom); cmd_rs2 = 2'($urandom); cmd_imm = 4'($urandom);
    if (!ld) begin
      m_s = op; m_a = m_reg[rs1]; m_b = m_reg[rs2];
      checks++;
      if ({S, A, B, rsp_valid, cmd_ready} !== {m_s, m_a, m_b, 2'b00}) begin
        errs++;
        $display("FAIL exec_sab: got S=%0d A=%0d B=%0d v=%b r=%b want S=%0d A=%0d B=%0d v=0 r=0",
                 S, A, B, rsp_valid, cmd_ready, m_s, m_a, m_b);
      end
      exp_d = alu_ref(op, m_a, m_b);
      m_reg[rd] = exp_d[3:0];
      m_flag = exp_d[4];
      @(negedge clk);
    end else begin
      exp_d = {1'b0, imm};
      m_reg[rd] = imm;
    end
    for (int k = 0; k <= stall; k++) begin
      checks++;
      if ({rsp_valid, cmd_ready, rsp_data, rsp_rd, flag, S, A, B} !==
          {2'b10, exp_d, rd, m_flag, m_s, m_a, m_b}) begin
        errs++;
        $display("FAIL resp: got v=%b r=%b d=%0d rd=%0d f=%b S=%0d A=%0d B=%0d want v=1 r=0 d=%0d rd=%0d f=%b S=%0d A=%0d B=%0d",
                 rsp_valid, cmd_ready, rsp_data, rsp_rd, flag, S, A, B,
                 exp_d, rd, m_flag, m_s, m_a, m_b);
      end
      if (k < stall) begin
        cmd_valid = 1'($urandom_range(0, 1)); cmd_load = 1'b1;
        cmd_rd = 2'($urandom); cmd_imm = 4'($urandom);
        @(negedge clk);
        cmd_valid = 1'b0;
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      errs++;
      $display("FAIL back_to_idle: got ready=%b valid=%b want 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 3'd0; cmd_rd = 2'd0;
    cmd_rs1 = 2'd0; cmd_rs2 = 2'd0; cmd_imm = 4'd0; rsp_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, S, A, B, rsp_data, rsp_rd, flag} !== {1'b1, 20'd0}) begin
      errs++;
      $display("FAIL reset_outputs: got r=%b v=%b S=%0d A=%0d B=%0d d=%0d rd=%0d f=%b want r=1 rest 0",
               cmd_ready, rsp_valid, S, A, B, rsp_data, rsp_rd, flag);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, S, A, B, rsp_data, rsp_rd, flag} !== {1'b1, 20'd0}) begin
      errs++;
      $display("FAIL idle_after_reset: got r=%b v=%b S=%0d A=%0d B=%0d d=%0d rd=%0d f=%b want r=1 rest 0",
               cmd_ready, rsp_valid, S, A, B, rsp_data, rsp_rd, flag);
    end
  endtask

  task automatic test_load_add();
    issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd9, 0);
    issue(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd8, 0);
    issue(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 4'd0, 0);
    checks++;
    if ({rsp_data, rsp_rd, flag} !== {5'd17, 2'd2, 1'b1}) begin
      errs++;
      $display("FAIL add_9_8: got d=%0d rd=%0d f=%b want d=17 rd=2 f=1", rsp_data, rsp_rd, flag);
    end
    issue(1'b0, 3'd3, 2'd3, 2'd2, 2'd2, 4'd0, 0);
    checks++;
    if (A !== 4'd1) begin
      errs++;
      $display("FAIL reg2_after_add: got %0d want 1", A);
    end
  endtask

  task automatic test_sub_wrap();
    issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd3, 0);
    issue(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd5, 0);
    issue(1'b0, 3'd1, 2'd3, 2'd0, 2'd1, 4'd0, 0);
    checks++;
    if ({rsp_data, flag} !== {5'd30, 1'b1}) begin
      errs++;
      $display("FAIL sub_wrap: got d=%0d f=%b want d=30 f=1", rsp_data, flag);
    end
    issue(1'b0, 3'd2, 2'd2, 2'd3, 2'd3, 4'd0, 0);
    checks++;
    if (rsp_data !== 5'd14) begin
      errs++;
      $display("FAIL reg3_after_sub: got %0d want 14", rsp_data);
    end
  endtask

  task automatic test_cmp_dep();
    issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd6, 0);
    issue(1'b0, 3'd6, 2'd1, 2'd0, 2'd0, 4'd0, 0);
    checks++;
    if (rsp_data !== 5'd1) begin
      errs++;
      $display("FAIL cmp_eq: got %0d want 1", rsp_data);
    end
    issue(1'b0, 3'd0, 2'd1, 2'd1, 2'd0, 4'd0, 0);
    checks++;
    if ({rsp_data, flag} !== {5'd7, 1'b0}) begin
      errs++;
      $display("FAIL dep_add: got d=%0d f=%b want d=7 f=0", rsp_data, flag);
    end
  endtask

  task automatic test_back_pressure();
    issue(1'b0, 3'd4, 2'd2, 2'd0, 2'd1, 4'd0, 5);
    issue(1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 4'd12, 5);
    issue(1'b0, 3'd5, 2'd0, 2'd3, 2'd3, 4'd0, 0);
    checks++;
    if ({rsp_data, flag} !== {5'd24, 1'b1}) begin
      errs++;
      $display("FAIL shl_flag: got d=%0d f=%b want d=24 f=1", rsp_data, flag);
    end
  endtask

  task automatic test_reset_mid_op();
    issue(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 4'd9, 0);
    issue(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 4'd8, 0);
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'd0; cmd_rd = 2'd2; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, S, A, B, rsp_data, rsp_rd, flag} !== {1'b1, 20'd0}) begin
      errs++;
      $display("FAIL reset_mid_exec: got r=%b v=%b S=%0d A=%0d B=%0d d=%0d rd=%0d f=%b want r=1 rest 0",
               cmd_ready, rsp_valid, S, A, B, rsp_data, rsp_rd, flag);
    end
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 3'd3, 2'd0, 2'd2, 2'd0, 4'd0, 0);
    issue(1'b0, 3'd3, 2'd0, 2'd1, 2'd3, 4'd0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      issue(1'($urandom_range(0, 2) == 0), 3'($urandom), 2'($urandom), 2'($urandom),
            2'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_sub_wrap();
    test_cmp_dep();
    test_back_pressure();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
